// File: rtl/square_pkg.sv
// Shared types and widths for the round-robin squarer arbiter.
package square_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam int SQ_IN_W  = 3;
  localparam int SQ_OUT_W = 6;

endpackage

// File: rtl/sq3_core.sv
// Purely combinational 3-bit to 6-bit unsigned squarer.
module sq3_core
  import square_pkg::*;
(
  input  logic [SQ_IN_W-1:0]  a,
  output logic [SQ_OUT_W-1:0] sq
);

  logic [SQ_OUT_W-1:0] a_ext;

  assign a_ext = {{(SQ_OUT_W-SQ_IN_W){1'b0}}, a};
  assign sq    = a_ext * a_ext;

endmodule

// File: rtl/square_arbiter.sv
// Round-robin sharing of one 3-bit squarer among N_REQ requesters, with a
// registered, back-pressurable result port tagged by requester index.
module square_arbiter
  import square_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [SQ_IN_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     res_valid,
  output logic [SQ_OUT_W-1:0]      res_data,
  output logic [IDW-1:0]           res_id,
  input  logic                     res_ready,
  output logic [7:0]               done_cnt
);

  state_t              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic                res_valid_q, res_valid_d;
  logic [SQ_OUT_W-1:0] res_data_q, res_data_d;
  logic [IDW-1:0]      res_id_q, res_id_d;
  logic [7:0]          done_cnt_q, done_cnt_d;

  logic [N_REQ-1:0]    rot_valid;
  logic [IDW-1:0]      win_off;
  logic [IDW-1:0]      win_id;
  logic                any_valid;
  logic                grant_en;
  logic                accept;
  logic [SQ_IN_W-1:0]  win_data;
  logic [SQ_OUT_W-1:0] win_sq;

  // Rotate so the pointer sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    int s;
    s         = 0;
    rot_valid = '0;
    win_off   = '0;
    any_valid = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      s = int'(ptr_q) + k;
      if (s >= N_REQ) s = s - N_REQ;
      rot_valid[k] = req_valid[s[IDW-1:0]];
    end
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        any_valid = 1'b1;
        win_off   = k[IDW-1:0];
      end
    end
    s = int'(win_off) + int'(ptr_q);
    if (s >= N_REQ) s = s - N_REQ;
    win_id = s[IDW-1:0];
  end

  assign grant_en  = (state_q == IDLE) | res_ready;
  assign req_ready = (any_valid & grant_en & ~rst) ? (N_REQ'(1) << win_id) : '0;
  assign accept    = |(req_valid & req_ready);
  assign win_data  = req_data[SQ_IN_W*int'(win_id) +: SQ_IN_W];

  sq3_core u_sq3_core (
    .a  (win_data),
    .sq (win_sq)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    done_cnt_d  = done_cnt_q;
    if (accept) begin
      state_d     = FULL;
      res_valid_d = 1'b1;
      res_data_d  = win_sq;
      res_id_d    = win_id;
      ptr_d       = (int'(win_id) == N_REQ - 1) ? '0 : win_id + 1'b1;
    end else if (state_q == FULL && res_ready) begin
      state_d     = IDLE;
      res_valid_d = 1'b0;
    end
    if (res_valid_q && res_ready) begin
      done_cnt_d = done_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign done_cnt  = done_cnt_q;

endmodule
